// File: rtl/tv80_bus_ctrl_if.sv
// Bus-cycle interface between the core, tv80_bus_ctrl and external memory/IO.
// The master side is the strobe generator; the slave side is the core/bus environment.
interface tv80_bus_ctrl_if #(
    parameter int DW = 8
);
    logic          cen;
    logic [6:0]    mc;
    logic [6:0]    ts;
    logic          intcycle_n;
    logic          no_read;
    logic          write;
    logic          iorq;
    logic          ext_wait_n;
    logic [DW-1:0] di;
    logic          wait_n;
    logic          rd_n;
    logic          wr_n;
    logic          mreq_n;
    logic          iorq_n;
    logic [DW-1:0] di_reg;

    modport master (
        input  cen, mc, ts, intcycle_n, no_read, write, iorq, ext_wait_n, di,
        output wait_n, rd_n, wr_n, mreq_n, iorq_n, di_reg
    );

    modport slave (
        output cen, mc, ts, intcycle_n, no_read, write, iorq, ext_wait_n, di,
        input  wait_n, rd_n, wr_n, mreq_n, iorq_n, di_reg
    );
endinterface

// File: rtl/tv80_bus_ctrl.sv
// Bus strobe generator for tv80_core: registered rd_n/wr_n/mreq_n/iorq_n,
// read-data capture, and a programmable wait-state counter merged with ext_wait_n.
module tv80_bus_ctrl #(
    parameter int DW       = 8,
    parameter int T2WRITE  = 1,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int REFRESH  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    tv80_bus_ctrl_if.master bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [3:0] MEM_N  = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N   = 4'(IO_WAIT);

    logic [0:0]    state;
    logic [3:0]    cnt;
    logic          int_wait;
    logic          active;
    logic          internal;
    logic [3:0]    load_n;
    logic          rd_d, wr_d, mreq_d, iorq_d;
    logic          rd_q, wr_q, mreq_q, iorq_q;
    logic [DW-1:0] di_q;
    logic          unused_ok;

    assign int_wait   = (state == S_WAIT);
    assign bus.wait_n = bus.ext_wait_n & ~int_wait;
    // A strobe is (re)asserted on T1 and held through every stretched T2.
    assign active     = bus.ts[1] | (bus.ts[2] & ~bus.wait_n);
    // Non-M1 cycle with no bus transfer: no wait states inserted.
    assign internal   = ~bus.mc[0] & bus.no_read & ~bus.write;
    assign load_n     = (bus.iorq | ~bus.intcycle_n) ? IO_N : MEM_N;

    assign bus.rd_n   = rd_q;
    assign bus.wr_n   = wr_q;
    assign bus.mreq_n = mreq_q;
    assign bus.iorq_n = iorq_q;
    assign bus.di_reg = di_q;
    assign unused_ok  = ^{bus.mc[6:1], bus.ts[6:4], bus.ts[0]};

    // Next strobe values: all idle high unless a bus rule claims them.
    always_comb begin
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        mreq_d = 1'b1;
        iorq_d = 1'b1;
        if (bus.mc[0]) begin
            if (active) begin
                rd_d   = ~bus.intcycle_n;
                mreq_d = ~bus.intcycle_n;
                iorq_d = bus.intcycle_n;
            end
            if (bus.ts[3] && (REFRESH != 0))
                mreq_d = 1'b0;
        end else begin
            if (active && !bus.no_read && !bus.write) begin
                rd_d   = 1'b0;
                iorq_d = ~bus.iorq;
                mreq_d = bus.iorq;
            end
            if (bus.write) begin
                wr_d = (T2WRITE != 0) ? ~active : ~bus.ts[2];
                // Address-space request accompanies the write strobe.
                if (active || !wr_d) begin
                    iorq_d = ~bus.iorq;
                    mreq_d = bus.iorq;
                end
            end
        end
    end

    // Register strobes on enabled clocks; reset forces every strobe inactive at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            mreq_q <= 1'b1;
            iorq_q <= 1'b1;
        end else if (bus.cen) begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            mreq_q <= mreq_d;
            iorq_q <= iorq_d;
        end
    end

    // Wait-state counter: loaded on T1, counts down independently of ext_wait_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else if (bus.cen) begin
            case (state)
                S_IDLE: begin
                    if (bus.ts[1] && !internal && (load_n != 4'd0)) begin
                        state <= S_WAIT;
                        cnt   <= load_n;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Capture read data on the final T2, the one the core actually proceeds from.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            di_q <= '0;
        else if (bus.cen && bus.ts[2] && bus.wait_n)
            di_q <= bus.di;
    end
endmodule
